// File: rtl/scarv_cop_sha3_idx_seq.sv
// rtl/scarv_cop_sha3_idx_seq.sv - Keccak lane-index burst sequencer with valid/ready output
module scarv_cop_sha3_idx_seq #(
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 2,
  parameter int CNT_W   = 5
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_mode,
  input  logic [2:0]         cmd_x,
  input  logic [2:0]         cmd_y,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_idx,
  output logic               out_last,
  output logic               done,
  output logic               busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic [2:0]         xs, ys, mode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [CNT_W-1:0]   rem_q;      // beats left, including the one on the bus
  logic [2:0]         cx, cy, nx, ny;
  logic               accept, hs;

  function automatic logic [2:0] mod5(input logic [2:0] v);
    return (v >= 3'd5) ? (v - 3'd5) : v;
  endfunction

  // Lane number for (x,y) in the given mode, then widened and shifted.
  function automatic logic [OUT_W-1:0] lane_idx(input logic [2:0] x, input logic [2:0] y,
                                                input logic [2:0] m, input logic [SHAMT_W-1:0] sh);
    logic [4:0] xa, ya, lane;
    logic [OUT_W-1:0] wide;
    xa   = {2'b00, x};
    ya   = {2'b00, y};
    lane = 5'd0;
    case (m)
      3'd0:    lane = xa + 5'd5 * ya;
      3'd1:    lane = ((xa + 5'd1) % 5'd5) + 5'd5 * ya;
      3'd2:    lane = ((xa + 5'd2) % 5'd5) + 5'd5 * ya;
      3'd3:    lane = ((xa + 5'd4) % 5'd5) + 5'd5 * ya;
      3'd4:    lane = ya + 5'd5 * ((5'd2 * xa + 5'd3 * ya) % 5'd5);
      default: lane = 5'd0;
    endcase
    wide = OUT_W'(lane);
    return wide << sh;
  endfunction

  assign cx     = mod5(cmd_x);
  assign cy     = mod5(cmd_y);
  // x walks fastest; y advances when x wraps, so 25 beats cover the whole state.
  assign nx     = (xs == 3'd4) ? 3'd0 : xs + 3'd1;
  assign ny     = (xs == 3'd4) ? ((ys == 3'd4) ? 3'd0 : ys + 3'd1) : ys;
  assign accept = cmd_valid && cmd_ready;
  assign hs     = out_valid && out_ready;

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and state-decoded status outputs; abort beats a handshake.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept && (cmd_count != '0)) state_d = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (abort)                state_d = IDLE;
        else if (hs && out_last)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the command, present registered beats, step on handshake.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      xs        <= 3'd0;
      ys        <= 3'd0;
      mode_q    <= 3'd0;
      shamt_q   <= '0;
      rem_q     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          xs      <= cx;
          ys      <= cy;
          mode_q  <= cmd_mode;
          shamt_q <= cmd_shamt;
          rem_q   <= cmd_count;
          if (cmd_count == '0) begin
            done <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_idx   <= lane_idx(cx, cy, cmd_mode, cmd_shamt);
            out_last  <= (cmd_count == CNT_W'(1));
          end
        end
      end else if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b1;
        end else begin
          xs       <= nx;
          ys       <= ny;
          rem_q    <= rem_q - CNT_W'(1);
          out_idx  <= lane_idx(nx, ny, mode_q, shamt_q);
          out_last <= (rem_q == CNT_W'(2));
        end
      end
    end
  end

endmodule

// File: doc/scarv_cop_sha3_idx_seq.md
Name: scarv_cop_sha3_idx_seq

Overview:
Multi-cycle Keccak lane-index sequencer for the co-processor SHA3 path. One command produces a stream of lane indices (x,y mod 5, five addressing modes) over a valid/ready handshake, instead of one index per instruction. It sits between the SHA3 instruction decode and the CPR/memory address path, so load/store loops over the 5x5 state can be driven without per-lane index instructions.
- Generalised in output width, shift width and burst length.

Parameters:
OUT_W, 32, width of out_idx.
SHAMT_W, 2, width of cmd_shamt; index is left-shifted by cmd_shamt.
CNT_W, 5, width of cmd_count; max burst length 2^CNT_W-1.

Ports:
g_clk  in  1  clock, rising edge.
g_resetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready.
cmd_mode  in  3  0=XY, 1=X1, 2=X2, 3=X4, 4=YX; 5-7 illegal.
cmd_x  in  3  start x, 0-7, reduced mod 5 at accept.
cmd_y  in  3  start y, 0-7, reduced mod 5 at accept.
cmd_count  in  CNT_W  number of indices to emit; 0 is legal.
cmd_shamt  in  SHAMT_W  left shift applied to every index.
abort  in  1  synchronous cancel of the current burst.
out_valid  out  1  out_idx is valid.
out_ready  in  1  consumer accepts the beat.
out_idx  out  OUT_W  lane index, zero-extended, then shifted.
out_last  out  1  marks the final beat of the burst.
done  out  1  single-cycle pulse when the burst completes normally.
busy  out  1  high in EMIT.

Behaviour:
- Reset: the asynchronous reset clears all registers. Outputs after reset: cmd_ready=1, out_valid=0, out_idx=0, out_last=0, done=0, busy=0. State is IDLE.
- State register xs/ys holds values 0-4 only. Load is xs=cmd_x%5, ys=cmd_y%5. Mode, shamt and remaining count are latched at accept.
- Index function, with sums taken mod 5 and done in at least 5-bit arithmetic:
  - XY: xs + 5*ys
  - X1: (xs+1)%5 + 5*ys
  - X2: (xs+2)%5 + 5*ys
  - X4: (xs+4)%5 + 5*ys
  - YX: ys + 5*((2*xs+3*ys)%5)
  - Illegal mode: 0.
  - Result is shifted left by shamt and truncated to OUT_W.
- Step after each beat: xs=xs+1; when xs wraps 4->0, ys=ys+1 (4->0). For bursts longer than 25 the sequence repeats from (0,0).
- IDLE:
  - Accept with count>0: go to EMIT. Next cycle out_valid=1 with the index of the start (x,y); out_last=(count==1). Accept-to-first-beat latency is 1 cycle.
  - Accept with count==0: stay in IDLE, pulse done the next cycle, no out_valid.
- EMIT:
  - out_idx, out_last and out_valid are registered and held stable while out_valid&&!out_ready.
  - On handshake of a non-last beat, the next index is presented the following cycle. Throughput is 1 beat/cycle with no bubbles.
  - On handshake of the last beat: out_valid=0 next cycle, done=1 for exactly that one cycle, return to IDLE. cmd_ready=1 in that same cycle.
- abort (any state, highest priority over handshake): next cycle state=IDLE, out_valid=0, out_last=0, no done pulse. An abort in IDLE has no effect.
- cmd_valid while busy is ignored (cmd_ready=0). The command is not queued.
- Reset mid-burst: immediately returns to the reset values above; no done.

Test Plan:
- XY, x=0,y=0, count=3, shamt=2, out_ready=1 -> out_idx 0,4,8 on consecutive cycles; out_last on the 3rd beat; done 1 cycle after it.
- XY, x=4,y=4, count=2, shamt=0 -> 24 then 0 (x and y wrap); X4, x=3,y=4, count=1 -> 22 with out_last=1.
- YX, x=1,y=0, count=2, shamt=0 -> 10, then 20; mode 6 -> out_idx 0.
- Input reduction: X1, x=7,y=6, count=1, shamt=0 -> x=2,y=1 gives 3+5=8. count=0 -> done pulse, out_valid never asserted.
- Backpressure: out_ready low for 3 cycles on beat 2 of XY count=4 -> out_idx=1 held stable; sequence 0,1,2,3 resumes with no loss or duplication. cmd_valid during the burst -> ignored.
- abort asserted mid-burst, and g_resetn pulsed low mid-burst -> out_valid=0 next cycle (reset: immediately), no done; a new command is accepted the following cycle.
